// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared definitions for the dual switch debouncer:
//   - db_state_t            : 2-bit debounce FSM state encoding
//   - DEFAULT_STABLE_CYCLES : default acceptance window (10 ms at 100 MHz)
// -----------------------------------------------------------------------------
package debounce_pkg;

  // Debounce FSM states. The steady states carry the accepted level, the WAIT
  // states qualify a candidate opposite level.
  typedef enum logic [1:0] {
    ST_LO   = 2'd0,
    WAIT_HI = 2'd1,
    ST_HI   = 2'd2,
    WAIT_LO = 2'd3
  } db_state_t;

  // Consecutive synchronised cycles a new level must hold to be accepted.
  localparam int unsigned DEFAULT_STABLE_CYCLES = 32'd1_000_000;

endpackage : debounce_pkg

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One independent debounce channel: two-flop synchroniser, four-state
// debounce FSM with qualification counter, registered clean level and
// registered single-cycle edge pulses.
//
// Parameters:
//   STABLE_CYCLES : synchronised cycles a new level must hold (2 .. 2^24)
//   CNT_W         : counter width, derived from STABLE_CYCLES
// Ports:
//   clk  in  system clock, rising edge
//   rst  in  asynchronous active-high reset
//   raw  in  raw switch level, asynchronous to clk
//   db   out debounced level (1 in ST_HI and WAIT_LO)
//   rise out one-cycle pulse on the cycle db first reads 1
//   fall out one-cycle pulse on the cycle db first reads 0
// -----------------------------------------------------------------------------
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int          CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall
);

  // Terminal count: the candidate level has then been seen STABLE_CYCLES+1
  // times (one sample in the steady state plus STABLE_CYCLES in the WAIT).
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

  logic             s1_r;
  logic             s_r;
  db_state_t        state_r;
  db_state_t        state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic             db_r;
  logic             db_s;
  logic             rise_r;
  logic             rise_s;
  logic             fall_r;
  logic             fall_s;

  // Next-state, counter and output decode for the debounce FSM.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_LO: begin
        if (s_r) begin
          state_s = WAIT_HI;
          cnt_s   = '0;
        end else begin
          state_s = ST_LO;
        end
      end
      WAIT_HI: begin
        // Terminal compare comes before the increment, so cnt never wraps.
        if (!s_r) begin
          state_s = ST_LO;
          cnt_s   = '0;
        end else if (cnt_r == CNT_LAST) begin
          state_s = ST_HI;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      ST_HI: begin
        if (!s_r) begin
          state_s = WAIT_LO;
          cnt_s   = '0;
        end else begin
          state_s = ST_HI;
        end
      end
      WAIT_LO: begin
        if (s_r) begin
          state_s = ST_HI;
          cnt_s   = '0;
        end else if (cnt_r == CNT_LAST) begin
          state_s = ST_LO;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = ST_LO;
        cnt_s   = '0;
      end
    endcase

    // db follows the state about to be entered, so the registered copy never
    // moves while the FSM sits in a WAIT state.
    db_s   = (state_s == ST_HI) || (state_s == WAIT_LO);
    rise_s = (state_r == WAIT_HI) && (state_s == ST_HI);
    fall_s = (state_r == WAIT_LO) && (state_s == ST_LO);
  end

  // Synchroniser, FSM state, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_r    <= 1'b0;
      s_r     <= 1'b0;
      state_r <= ST_LO;
      cnt_r   <= '0;
      db_r    <= 1'b0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      s1_r    <= raw;
      s_r     <= s1_r;
      state_r <= state_s;
      cnt_r   <= cnt_s;
      db_r    <= db_s;
      rise_r  <= rise_s;
      fall_r  <= fall_s;
    end
  end

  assign db   = db_r;
  assign rise = rise_r;
  assign fall = fall_r;

endmodule : debounce_channel

// File: rtl/dual_switch_debouncer.sv
// -----------------------------------------------------------------------------
// dual_switch_debouncer
// Conditions two raw switch levels into clean, clock-synchronous levels for
// the downstream logic (db1 -> in1, db2 -> in2) plus edge pulses. The two
// channels are identical and independent; this level only wires them up.
//
// Parameters:
//   STABLE_CYCLES : synchronised cycles a new level must hold (2 .. 2^24)
//   CNT_W         : counter width, derived; do not override
// Ports:
//   clk           in  system clock, rising edge
//   rst           in  asynchronous active-high reset
//   raw1, raw2    in  raw switch levels, asynchronous to clk
//   db1, db2      out debounced levels
//   rise1, fall1  out one-cycle pulses on db1 0->1 / 1->0
//   rise2, fall2  out one-cycle pulses on db2 0->1 / 1->0
// -----------------------------------------------------------------------------
module dual_switch_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int          CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw1,
  input  logic raw2,
  output logic db1,
  output logic db2,
  output logic rise1,
  output logic fall1,
  output logic rise2,
  output logic fall2
);

  debounce_channel #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_ch1 (
    .clk  (clk),
    .rst  (rst),
    .raw  (raw1),
    .db   (db1),
    .rise (rise1),
    .fall (fall1)
  );

  debounce_channel #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_ch2 (
    .clk  (clk),
    .rst  (rst),
    .raw  (raw2),
    .db   (db2),
    .rise (rise2),
    .fall (fall2)
  );

endmodule : dual_switch_debouncer

// File: tb/tb_dual_switch_debouncer.sv
// -----------------------------------------------------------------------------
// tb_dual_switch_debouncer
// Directed bench for dual_switch_debouncer with STABLE_CYCLES = 4. A
// behavioural model states the acceptance rule directly: db flips once the
// synchronised input has disagreed with db for STABLE_CYCLES+1 consecutive
// samples. Outputs are compared against it every cycle; hand-computed
// literal checks pin the latency and pulse counts of each scenario.
// -----------------------------------------------------------------------------
module tb_dual_switch_debouncer;

  localparam int SC = 4;

  logic       clk;
  logic       rst;
  logic [1:0] raw_v;
  logic       db1, db2, rise1, fall1, rise2, fall2;

  int n_tests;
  int n_fail;

  dual_switch_debouncer #(.STABLE_CYCLES(SC)) dut (
    .clk   (clk),
    .rst   (rst),
    .raw1  (raw_v[0]),
    .raw2  (raw_v[1]),
    .db1   (db1),
    .db2   (db2),
    .rise1 (rise1),
    .fall1 (fall1),
    .rise2 (rise2),
    .fall2 (fall2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    n_tests = n_tests + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_tests = n_tests + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // h1/h2: raw value taken at the previous edge and the one before it; the
  // debounce decision at an edge sees the value from two edges earlier.
  logic m_h1 [2];
  logic m_h2 [2];
  logic m_db [2];
  logic m_rise [2];
  logic m_fall [2];
  int   m_run [2];

  // Model update on every clock edge; clears immediately on reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        m_h1[c]   <= 1'b0;
        m_h2[c]   <= 1'b0;
        m_db[c]   <= 1'b0;
        m_rise[c] <= 1'b0;
        m_fall[c] <= 1'b0;
        m_run[c]  <= 0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        automatic int   r  = m_run[c];
        automatic logic d  = m_db[c];
        automatic logic rs = 1'b0;
        automatic logic fl = 1'b0;
        if (m_h2[c] != d) r = r + 1;
        else              r = 0;
        if (r == SC + 1) begin
          rs = ~d;
          fl = d;
          d  = ~d;
          r  = 0;
        end
        m_run[c]  <= r;
        m_db[c]   <= d;
        m_rise[c] <= rs;
        m_fall[c] <= fl;
        m_h2[c]   <= m_h1[c];
        m_h1[c]   <= raw_v[c];
      end
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(posedge clk) begin
    #1;
    chk("db1",   db1,   m_db[0]);
    chk("rise1", rise1, m_rise[0]);
    chk("fall1", fall1, m_fall[0]);
    chk("db2",   db2,   m_db[1]);
    chk("rise2", rise2, m_rise[1]);
    chk("fall2", fall2, m_fall[1]);
  end

  // Observed pulse counters (scenarios compare differences).
  int n_rise [2];
  int n_fall [2];
  initial begin
    for (int c = 0; c < 2; c++) begin
      n_rise[c] = 0;
      n_fall[c] = 0;
    end
  end
  always @(posedge clk) begin
    #1;
    if (rise1) n_rise[0] <= n_rise[0] + 1;
    if (fall1) n_fall[0] <= n_fall[0] + 1;
    if (rise2) n_rise[1] <= n_rise[1] + 1;
    if (fall2) n_fall[1] <= n_fall[1] + 1;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int r0, f0, r1, f1;
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    raw_v   = 2'b11;

    // Reset with both raw inputs high: everything held at 0.
    cycles(3);
    chk("rst_db1", db1, 1'b0);
    chk("rst_db2", db2, 1'b0);
    chk("rst_rise1", rise1, 1'b0);
    chk("rst_rise2", rise2, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #2;
      chk($sformatf("rel_db1_e%0d", k), db1, (k >= 6) ? 1'b1 : 1'b0);
      chk($sformatf("rel_db2_e%0d", k), db2, (k >= 6) ? 1'b1 : 1'b0);
      chk($sformatf("rel_rise1_e%0d", k), rise1, (k == 6) ? 1'b1 : 1'b0);
      chk($sformatf("rel_rise2_e%0d", k), rise2, (k == 6) ? 1'b1 : 1'b0);
    end

    // Clean press on channel 1 with channel 2 held high.
    @(negedge clk); raw_v[0] = 1'b0;
    cycles(10);
    chk("press_pre_db1", db1, 1'b0);
    raw_v[0] = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #2;
      chk($sformatf("press_db1_e%0d", k), db1, (k >= 6) ? 1'b1 : 1'b0);
      chk($sformatf("press_rise1_e%0d", k), rise1, (k == 6) ? 1'b1 : 1'b0);
      chk($sformatf("press_db2_e%0d", k), db2, 1'b1);
    end

    // Bounce from the low level: no change, no pulses.
    @(negedge clk); raw_v[0] = 1'b0;
    cycles(10);
    r0 = n_rise[0]; f0 = n_fall[0];
    for (int i = 0; i < 4; i++) begin
      raw_v[0] = (i % 2 == 0) ? 1'b1 : 1'b0;
      cycles(2);
    end
    raw_v[0] = 1'b0;
    cycles(10);
    chk_int("bounce_lo_rise1", n_rise[0] - r0, 0);
    chk_int("bounce_lo_fall1", n_fall[0] - f0, 0);
    chk("bounce_lo_db1", db1, 1'b0);

    // Bounce from the high level.
    raw_v[0] = 1'b1;
    cycles(10);
    chk("bounce_hi_pre_db1", db1, 1'b1);
    r0 = n_rise[0]; f0 = n_fall[0];
    for (int i = 0; i < 4; i++) begin
      raw_v[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
      cycles(2);
    end
    raw_v[0] = 1'b1;
    cycles(10);
    chk_int("bounce_hi_rise1", n_rise[0] - r0, 0);
    chk_int("bounce_hi_fall1", n_fall[0] - f0, 0);
    chk("bounce_hi_db1", db1, 1'b1);

    // Just short (4 samples) versus just long (5 samples) on channel 2.
    raw_v[1] = 1'b0;
    cycles(10);
    chk("short_pre_db2", db2, 1'b0);
    r1 = n_rise[1]; f1 = n_fall[1];
    raw_v[1] = 1'b1;
    cycles(SC);
    raw_v[1] = 1'b0;
    cycles(12);
    chk_int("short_rise2", n_rise[1] - r1, 0);
    chk("short_db2", db2, 1'b0);
    r1 = n_rise[1]; f1 = n_fall[1];
    raw_v[1] = 1'b1;
    cycles(SC + 1);
    raw_v[1] = 1'b0;
    cycles(12);
    chk_int("long_rise2", n_rise[1] - r1, 1);
    chk_int("long_fall2", n_fall[1] - f1, 1);

    // Simultaneous opposite changes on both channels.
    raw_v = 2'b10;
    cycles(10);
    chk("sim_pre_db1", db1, 1'b0);
    chk("sim_pre_db2", db2, 1'b1);
    raw_v = 2'b01;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #2;
      chk($sformatf("sim_rise1_e%0d", k), rise1, (k == 6) ? 1'b1 : 1'b0);
      chk($sformatf("sim_fall2_e%0d", k), fall2, (k == 6) ? 1'b1 : 1'b0);
    end

    // Reset while channel 1 is counting in WAIT_HI.
    @(negedge clk); raw_v = 2'b00;
    cycles(10);
    chk("mid_pre_db1", db1, 1'b0);
    chk("mid_pre_db2", db2, 1'b0);
    raw_v[0] = 1'b1;
    repeat (5) @(posedge clk);   // edges 0..4: cnt has reached 2
    #2;
    r0 = n_rise[0];
    rst = 1'b1;
    #1;
    chk("mid_rst_db1", db1, 1'b0);
    chk("mid_rst_rise1", rise1, 1'b0);
    @(negedge clk); raw_v[0] = 1'b0;
    cycles(3);
    rst = 1'b0;
    cycles(4);
    chk_int("mid_rst_norise", n_rise[0] - r0, 0);
    raw_v[0] = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #2;
      chk($sformatf("repress_db1_e%0d", k), db1, (k >= 6) ? 1'b1 : 1'b0);
      chk($sformatf("repress_rise1_e%0d", k), rise1, (k == 6) ? 1'b1 : 1'b0);
    end

    cycles(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_dual_switch_debouncer
